// File: rtl/zeroheti_pkg.sv
// Shared register map, field positions and helpers for the zeroheti priority interrupt controller.
package zeroheti_pkg;

   localparam int unsigned LINE_STRIDE = 4;
   localparam logic [11:0] THRESH_OFFS = 12'h800;
   localparam logic [11:0] COUNT_OFFS  = 12'h804;

   localparam int unsigned IP_BIT   = 0;
   localparam int unsigned IE_BIT   = 1;
   localparam int unsigned TRIG_BIT = 2;
   localparam int unsigned PRIO_LSB = 8;

   typedef enum logic {
      TRIG_LEVEL = 1'b0,
      TRIG_EDGE  = 1'b1
   } trig_e;

   function automatic logic is_line_addr(input logic [11:0] addr, input int unsigned num_irqs);
      return ((32'(addr) % LINE_STRIDE) == 0) && ((32'(addr) / LINE_STRIDE) < num_irqs);
   endfunction

endpackage

// File: rtl/zeroheti_prio_tree.sv
// Combinational arbiter: highest priority above threshold wins, ties resolved to the lowest index.
module zeroheti_prio_tree #(
   parameter int unsigned NumIrqs = 32,
   parameter int unsigned NumPrio = 8,
   localparam int unsigned IW = $clog2(NumIrqs),
   localparam int unsigned PW = $clog2(NumPrio)
) (
   input  logic [NumIrqs-1:0]         pending_i,
   input  logic [NumIrqs-1:0][PW-1:0] prio_i,
   input  logic [PW-1:0]              thresh_i,
   output logic                       valid_o,
   output logic [IW-1:0]              id_o,
   output logic [PW-1:0]              level_o
);

   localparam int unsigned NumLeaves = 2 ** IW;
   localparam int unsigned NumNodes  = 2 * NumLeaves - 1;

   logic [NumNodes-1:0]         node_v;
   logic [NumNodes-1:0][IW-1:0] node_id;
   logic [NumNodes-1:0][PW-1:0] node_p;

   // Heap layout: node n has children 2n+1 (lower indices) and 2n+2; the left child wins ties.
   always_comb begin
      node_v  = '0;
      node_id = '0;
      node_p  = '0;
      for (int unsigned i = 0; i < NumLeaves; i++) begin
         if (i < NumIrqs) begin
            node_v[NumLeaves-1+i]  = pending_i[i] && (prio_i[i] > thresh_i);
            node_id[NumLeaves-1+i] = IW'(i);
            node_p[NumLeaves-1+i]  = prio_i[i];
         end
      end
      for (int unsigned k = NumLeaves - 1; k > 0; k--) begin
         if (node_v[2*k] && (!node_v[2*k-1] || (node_p[2*k] > node_p[2*k-1]))) begin
            node_v[k-1]  = node_v[2*k];
            node_id[k-1] = node_id[2*k];
            node_p[k-1]  = node_p[2*k];
         end else begin
            node_v[k-1]  = node_v[2*k-1];
            node_id[k-1] = node_id[2*k-1];
            node_p[k-1]  = node_p[2*k-1];
         end
      end
   end

   assign valid_o = node_v[0];
   assign id_o    = node_id[0];
   assign level_o = node_p[0];

endmodule

// File: rtl/zeroheti_prio_irq_ctrl.sv
// Priority interrupt controller with per-line ip/ie/trig/prio registers and a preemption threshold.
// Optional threshold nesting stack is enabled by defining ZEROHETI_IRQ_NEST_EN.
module zeroheti_prio_irq_ctrl
   import zeroheti_pkg::*;
#(
   parameter int unsigned NumIrqs   = 32,
   parameter int unsigned NumPrio   = 8,
   parameter int unsigned NestDepth = 4,
   localparam int unsigned IW = $clog2(NumIrqs),
   localparam int unsigned PW = $clog2(NumPrio)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NumIrqs-1:0] irqs_i,
   input  logic               reg_req_i,
   input  logic               reg_we_i,
   input  logic [11:0]        reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic               reg_gnt_o,
   output logic               reg_rvalid_o,
   output logic [31:0]        reg_rdata_o,
   output logic               irq_valid_o,
   output logic [IW-1:0]      irq_id_o,
   output logic [PW-1:0]      irq_level_o,
   input  logic               irq_ack_i,
   input  logic [IW-1:0]      irq_ack_id_i,
   input  logic               irq_exit_i
);

   localparam int unsigned CW = $clog2(NestDepth + 1);

   logic [NumIrqs-1:0]         ip_q, ip_d, ie_q, ie_d, trig_q, trig_d, irqs_q;
   logic [NumIrqs-1:0][PW-1:0] prio_q, prio_d;
   logic [PW-1:0]              thresh_q, thresh_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       rvalid_q;
   logic [31:0]                rdata_q, rdata_d;
   logic                       irq_valid_q;
   logic [IW-1:0]              irq_id_q;
   logic [PW-1:0]              irq_level_q;

   logic                       line_hit, line_wr, stack_full, sel_valid;
   logic [IW-1:0]              line_idx;
   logic [PW-1:0]              ack_prio;
   logic                       tree_valid;
   logic [IW-1:0]              tree_id;
   logic [PW-1:0]              tree_level;
   logic                       unused_wdata;

   assign unused_wdata = ^{reg_wdata_i[31:PRIO_LSB+PW], reg_wdata_i[PRIO_LSB-1:TRIG_BIT+1]};

   assign line_hit = is_line_addr(reg_addr_i, NumIrqs);
   assign line_idx = IW'(32'(reg_addr_i) / LINE_STRIDE);
   assign line_wr  = reg_req_i && reg_we_i && line_hit;
   assign ack_prio = (32'(irq_ack_id_i) < NumIrqs) ? prio_q[irq_ack_id_i] : '0;

   // Line state: software write, then ack clear, then a fresh hardware edge has the last word.
   always_comb begin
      ie_d   = ie_q;
      trig_d = trig_q;
      prio_d = prio_q;
      ip_d   = ip_q;
      if (line_wr) begin
         ie_d[line_idx]   = reg_wdata_i[IE_BIT];
         trig_d[line_idx] = reg_wdata_i[TRIG_BIT];
         prio_d[line_idx] = reg_wdata_i[PRIO_LSB +: PW];
      end
      for (int unsigned i = 0; i < NumIrqs; i++) begin
         if (trig_q[i] == TRIG_LEVEL) begin
            ip_d[i] = irqs_i[i];
         end else begin
            if (line_wr && (32'(line_idx) == i)) ip_d[i] = reg_wdata_i[IP_BIT];
            if (irq_ack_i && (32'(irq_ack_id_i) == i)) ip_d[i] = 1'b0;
            if (irqs_i[i] && !irqs_q[i]) ip_d[i] = 1'b1;
         end
      end
   end

`ifdef ZEROHETI_IRQ_NEST_EN
   logic [NestDepth-1:0][PW-1:0] stack_q, stack_d;

   // Exit pops before ack pushes so a same-cycle exit/ack pair hands over cleanly.
   always_comb begin
      stack_d  = stack_q;
      thresh_d = thresh_q;
      cnt_d    = cnt_q;
      if (irq_exit_i) begin
         if (cnt_d != '0) begin
            cnt_d    = cnt_d - CW'(1);
            thresh_d = stack_q[cnt_d];
         end else begin
            thresh_d = '0;
         end
      end
      if (irq_ack_i && (32'(cnt_d) < NestDepth)) begin
         stack_d[cnt_d] = thresh_d;
         cnt_d          = cnt_d + CW'(1);
         thresh_d       = ack_prio;
      end
   end

   assign stack_full = (32'(cnt_q) == NestDepth);

   always_ff @(posedge clk_i) begin
      if (rst_i) stack_q <= '0;
      else       stack_q <= stack_d;
   end
`else
   always_comb begin
      thresh_d = thresh_q;
      cnt_d    = '0;
      if (irq_exit_i) thresh_d = '0;
      if (irq_ack_i)  thresh_d = ack_prio;
   end

   assign stack_full = 1'b0;
`endif

   always_comb begin
      rdata_d = '0;
      if (reg_req_i && !reg_we_i) begin
         if (line_hit) begin
            rdata_d[IP_BIT]            = ip_q[line_idx];
            rdata_d[IE_BIT]            = ie_q[line_idx];
            rdata_d[TRIG_BIT]          = trig_q[line_idx];
            rdata_d[PRIO_LSB +: PW]    = prio_q[line_idx];
         end else if (reg_addr_i == THRESH_OFFS) begin
            rdata_d[PW-1:0] = thresh_q;
         end else if (reg_addr_i == COUNT_OFFS) begin
            rdata_d[CW-1:0] = cnt_q;
         end
      end
   end

   zeroheti_prio_tree #(
      .NumIrqs (NumIrqs),
      .NumPrio (NumPrio)
   ) u_tree (
      .pending_i (ip_q & ie_q),
      .prio_i    (prio_q),
      .thresh_i  (thresh_q),
      .valid_o   (tree_valid),
      .id_o      (tree_id),
      .level_o   (tree_level)
   );

   assign sel_valid = tree_valid && !stack_full;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ip_q        <= '0;
         ie_q        <= '0;
         trig_q      <= '0;
         prio_q      <= '0;
         irqs_q      <= '0;
         thresh_q    <= '0;
         cnt_q       <= '0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         irq_valid_q <= 1'b0;
         irq_id_q    <= '0;
         irq_level_q <= '0;
      end else begin
         ip_q        <= ip_d;
         ie_q        <= ie_d;
         trig_q      <= trig_d;
         prio_q      <= prio_d;
         irqs_q      <= irqs_i;
         thresh_q    <= thresh_d;
         cnt_q       <= cnt_d;
         rvalid_q    <= reg_req_i;
         rdata_q     <= rdata_d;
         irq_valid_q <= sel_valid;
         irq_id_q    <= sel_valid ? tree_id : '0;
         irq_level_q <= sel_valid ? tree_level : '0;
      end
   end

   assign reg_gnt_o    = reg_req_i;
   assign reg_rvalid_o = rvalid_q;
   assign reg_rdata_o  = rdata_q;
   assign irq_valid_o  = irq_valid_q;
   assign irq_id_o     = irq_id_q;
   assign irq_level_o  = irq_level_q;

endmodule

// File: tb/tb_zeroheti_prio_irq_ctrl.sv
// Self-checking bench for zeroheti_prio_irq_ctrl: directed scenarios plus random traffic against a reference model.
module tb_zeroheti_prio_irq_ctrl;

   localparam int NUM   = 32;
   localparam int NPRIO = 8;
   localparam int DEPTH = 4;
`ifdef ZEROHETI_IRQ_NEST_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [NUM-1:0]  irqs_i;
   logic            reg_req_i, reg_we_i;
   logic [11:0]     reg_addr_i;
   logic [31:0]     reg_wdata_i;
   logic            reg_gnt_o, reg_rvalid_o;
   logic [31:0]     reg_rdata_o;
   logic            irq_valid_o;
   logic [4:0]      irq_id_o;
   logic [2:0]      irq_level_o;
   logic            irq_ack_i;
   logic [4:0]      irq_ack_id_i;
   logic            irq_exit_i;

   zeroheti_prio_irq_ctrl #(
      .NumIrqs   (NUM),
      .NumPrio   (NPRIO),
      .NestDepth (DEPTH)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .irqs_i       (irqs_i),
      .reg_req_i    (reg_req_i),
      .reg_we_i     (reg_we_i),
      .reg_addr_i   (reg_addr_i),
      .reg_wdata_i  (reg_wdata_i),
      .reg_gnt_o    (reg_gnt_o),
      .reg_rvalid_o (reg_rvalid_o),
      .reg_rdata_o  (reg_rdata_o),
      .irq_valid_o  (irq_valid_o),
      .irq_id_o     (irq_id_o),
      .irq_level_o  (irq_level_o),
      .irq_ack_i    (irq_ack_i),
      .irq_ack_id_i (irq_ack_id_i),
      .irq_exit_i   (irq_exit_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit   m_ip [NUM];
   bit   m_ie [NUM];
   bit   m_trig [NUM];
   bit   m_prev [NUM];
   int   m_prio [NUM];
   int   m_thresh;
   int   m_stack [$];
   bit   e_valid, e_rvalid;
   int   e_id, e_level;
   logic [31:0] e_rdata;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a);
      int idx = int'(a) / 4;
      if (a[1:0] == 2'b00 && idx < NUM)
         return 32'(m_ip[idx]) | (32'(m_ie[idx]) << 1) | (32'(m_trig[idx]) << 2) | (32'(m_prio[idx]) << 8);
      if (a == 12'h800) return 32'(m_thresh);
      if (a == 12'h804) return NEST ? 32'(m_stack.size()) : 32'd0;
      return 32'd0;
   endfunction

   task automatic model_tick();
      bit nip [NUM];
      int best, bp, idx, ap;
      bit wr, full;
      if (rst_i) begin
         for (int i = 0; i < NUM; i++) begin
            m_ip[i] = 0; m_ie[i] = 0; m_trig[i] = 0; m_prev[i] = 0; m_prio[i] = 0;
         end
         m_thresh = 0;
         m_stack.delete();
         e_valid = 0; e_id = 0; e_level = 0; e_rvalid = 0; e_rdata = '0;
         return;
      end
      best = -1;
      bp   = 0;
      for (int i = 0; i < NUM; i++)
         if (m_ip[i] && m_ie[i] && m_prio[i] > m_thresh && m_prio[i] > bp) begin
            best = i;
            bp   = m_prio[i];
         end
      full     = NEST && (m_stack.size() == DEPTH);
      e_valid  = (best >= 0) && !full;
      e_id     = e_valid ? best : 0;
      e_level  = e_valid ? bp : 0;
      e_rvalid = reg_req_i;
      e_rdata  = (reg_req_i && !reg_we_i) ? model_read(reg_addr_i) : 32'd0;

      idx = int'(reg_addr_i) / 4;
      wr  = reg_req_i && reg_we_i && reg_addr_i[1:0] == 2'b00 && idx < NUM;
      ap  = m_prio[irq_ack_id_i];
      for (int i = 0; i < NUM; i++) begin
         if (!m_trig[i]) nip[i] = irqs_i[i];
         else begin
            nip[i] = m_ip[i];
            if (wr && idx == i) nip[i] = reg_wdata_i[0];
            if (irq_ack_i && irq_ack_id_i == 5'(i)) nip[i] = 0;
            if (irqs_i[i] && !m_prev[i]) nip[i] = 1;
         end
      end
      for (int i = 0; i < NUM; i++) begin
         m_ip[i]   = nip[i];
         m_prev[i] = irqs_i[i];
      end
      if (wr) begin
         m_ie[idx]   = reg_wdata_i[1];
         m_trig[idx] = reg_wdata_i[2];
         m_prio[idx] = int'(reg_wdata_i >> 8) % NPRIO;
      end
      if (irq_exit_i) begin
         if (NEST && m_stack.size() > 0) m_thresh = m_stack.pop_back();
         else m_thresh = 0;
      end
      if (irq_ack_i) begin
         if (!NEST) m_thresh = ap;
         else if (m_stack.size() < DEPTH) begin
            m_stack.push_back(m_thresh);
            m_thresh = ap;
         end
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      model_tick();
      @(negedge clk_i);
      check_eq("irq_valid", 32'(irq_valid_o), 32'(e_valid));
      check_eq("irq_id", 32'(irq_id_o), 32'(e_id));
      check_eq("irq_level", 32'(irq_level_o), 32'(e_level));
      check_eq("rvalid", 32'(reg_rvalid_o), 32'(e_rvalid));
      check_eq("rdata", reg_rdata_o, e_rdata);
      check_eq("gnt", 32'(reg_gnt_o), 32'(reg_req_i));
   endtask

   task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
      reg_req_i = 1; reg_we_i = 1; reg_addr_i = a; reg_wdata_i = d;
      step();
      reg_req_i = 0; reg_we_i = 0;
   endtask

   task automatic reg_rd(input logic [11:0] a);
      reg_req_i = 1; reg_we_i = 0; reg_addr_i = a;
      step();
      reg_req_i = 0;
   endtask

   task automatic ack(input int id);
      irq_ack_i = 1; irq_ack_id_i = 5'(id);
      step();
      irq_ack_i = 0;
   endtask

   task automatic do_exit();
      irq_exit_i = 1;
      step();
      irq_exit_i = 0;
   endtask

   initial begin
      rst_i = 1; irqs_i = '0; reg_req_i = 0; reg_we_i = 0; reg_addr_i = '0; reg_wdata_i = '0;
      irq_ack_i = 0; irq_ack_id_i = '0; irq_exit_i = 0;
      @(negedge clk_i);
      step();
      step();
      check_eq("reset_valid", 32'(irq_valid_o), 32'd0);
      check_eq("reset_rdata", reg_rdata_o, 32'd0);
      rst_i = 0;
      step();

      // Edge line 3, prio 5: output two cycles after the rising edge is presented
      reg_wr(12'h00C, 32'h506);
      irqs_i[3] = 1;
      step();
      check_eq("edge_cycle1_valid", 32'(irq_valid_o), 32'd0);
      step();
      check_eq("edge_valid", 32'(irq_valid_o), 32'd1);
      check_eq("edge_id", 32'(irq_id_o), 32'd3);
      check_eq("edge_level", 32'(irq_level_o), 32'd5);

      // Software clear racing a new edge: the edge wins
      irqs_i[3] = 0;
      step();
      irqs_i[3] = 1;
      reg_wr(12'h00C, 32'h506);
      reg_rd(12'h00C);
      check_eq("sw_clear_vs_edge", reg_rdata_o, 32'h507);
      step();

      // Ack raises the threshold above a pending prio-4 line; exit restores it
      ack(3);
      irqs_i[7] = 1;
      reg_wr(12'h01C, 32'h402);
      step();
      step();
      check_eq("masked_valid", 32'(irq_valid_o), 32'd0);
      reg_rd(12'h800);
      check_eq("thresh_after_ack", reg_rdata_o, 32'd5);
      do_exit();
      step();
      check_eq("exit_valid", 32'(irq_valid_o), 32'd1);
      check_eq("exit_id", 32'(irq_id_o), 32'd7);

      // Equal priorities tie to the lower index; raising line 9 flips the winner
      irqs_i[4] = 1; irqs_i[9] = 1;
      reg_wr(12'h010, 32'h602);
      reg_wr(12'h024, 32'h602);
      step();
      step();
      check_eq("tie_id", 32'(irq_id_o), 32'd4);
      reg_wr(12'h024, 32'h702);
      step();
      check_eq("raise_id", 32'(irq_id_o), 32'd9);
      check_eq("raise_level", 32'(irq_level_o), 32'd7);

      // Reset in the middle of nested handling
      ack(3);
      ack(3);
      reg_rd(12'h804);
      check_eq("count_before_rst", reg_rdata_o, NEST ? 32'd2 : 32'd0);
      rst_i = 1;
      step();
      rst_i = 0;
      irqs_i = '0;
      check_eq("rst_rvalid", 32'(reg_rvalid_o), 32'd0);
      reg_rd(12'h800);
      check_eq("rst_thresh", reg_rdata_o, 32'd0);
      reg_rd(12'h804);
      check_eq("rst_count", reg_rdata_o, 32'd0);
      reg_rd(12'h010);
      check_eq("rst_line_ie", reg_rdata_o & 32'h2, 32'd0);

`ifdef ZEROHETI_IRQ_NEST_EN
      // Fill the nesting stack: a higher-priority pending line must stay hidden
      reg_wr(12'h028, 32'h200);
      reg_wr(12'h02C, 32'h300);
      reg_wr(12'h030, 32'h400);
      reg_wr(12'h034, 32'h500);
      ack(10); ack(11); ack(12); ack(13);
      irqs_i[20] = 1;
      reg_wr(12'h050, 32'h702);
      step();
      step();
      check_eq("full_valid", 32'(irq_valid_o), 32'd0);
      reg_rd(12'h804);
      check_eq("full_count", reg_rdata_o, 32'd4);
      repeat (4) do_exit();
      step();
      step();
      check_eq("unfull_id", 32'(irq_id_o), 32'd20);
`endif

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         irqs_i = irqs_i ^ ($urandom() & $urandom() & $urandom());
         rst_i  = ($urandom_range(0, 299) == 0);
         reg_req_i = ($urandom_range(0, 9) < 3);
         reg_we_i  = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0, 1:    reg_addr_i = 12'($urandom_range(0, NUM - 1) * 4);
            2:       reg_addr_i = $urandom_range(0, 1) ? 12'h800 : 12'h804;
            default: reg_addr_i = 12'($urandom_range(0, 4095));
         endcase
         reg_wdata_i  = $urandom();
         irq_ack_i    = ($urandom_range(0, 99) < 15);
         irq_ack_id_i = (e_valid && $urandom_range(0, 3) != 0) ? 5'(e_id) : 5'($urandom_range(0, NUM - 1));
         irq_exit_i   = ($urandom_range(0, 99) < 10);
         step();
      end
      rst_i = 0; reg_req_i = 0; irq_ack_i = 0; irq_exit_i = 0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
